// File: rtl/uart_mmio_responder_pkg.sv
// Shared UART register-select encodings, TX FSM states
// and FIFO depth for the MMIO UART responder.
package uart_mmio_responder_pkg;

  localparam logic [1:0] UART_RXCTRL = 2'b00;
  localparam logic [1:0] UART_RXDATA = 2'b01;
  localparam logic [1:0] UART_TXCTRL = 2'b10;
  localparam logic [1:0] UART_TXDATA = 2'b11;

  localparam int TX_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_mmio_responder_tx.sv
// uart_tx_serializer: baud-timed 8N1 transmitter with a
// byte-in ready/valid port; SerialOut is registered.
module uart_tx_serializer
  import uart_mmio_responder_pkg::*;
#(
  parameter int SymbolEdgeTime = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       serial_out
);

  localparam int CntW = $clog2(SymbolEdgeTime);
  localparam logic [CntW-1:0] CntLast =
    CntW'(SymbolEdgeTime - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            serial_q, serial_d;
  logic            last;

  assign last       = (cnt_q == CntLast);
  assign in_ready   = (state_q == TX_IDLE);
  assign serial_out = serial_q;

  // Next-state: each symbol lasts SymbolEdgeTime cycles, LSB first
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    unique case (state_q)
      TX_IDLE: begin
        cnt_d    = '0;
        idx_d    = '0;
        serial_d = 1'b1;
        if (in_valid) begin
          shift_d  = in_byte;
          state_d  = TX_START;
          serial_d = 1'b0;
        end
      end
      TX_START: begin
        if (last) begin
          state_d  = TX_DATA;
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (last) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d  = TX_STOP;
            serial_d = 1'b1;
          end else begin
            idx_d    = idx_q + 3'd1;
            serial_d = shift_q[idx_d];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (last) begin
          state_d = TX_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // State register; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
    end
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// MMIO UART responder: RX holding register, read mux, TX path.
// Define UART_TX_FIFO_EN for a 4-entry TX FIFO.
module uart_mmio_responder
  import uart_mmio_responder_pkg::*;
#(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        REUART,
  input  logic        WEUART,
  input  logic [1:0]  UARTsel,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  RxByte,
  input  logic        RxValid,
  output logic        RxReady,
  output logic        SerialOut
);

  localparam int SymbolEdgeTime = ClockFreq / BaudRate;

  logic       rx_full_q, rx_full_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_push, rx_pop;
  logic       tx_hit, tx_ready;
  logic       ser_valid, ser_ready;
  logic [7:0] ser_byte;
  logic       unused_wdata;

  assign unused_wdata = ^WriteData[31:8];

  assign RxReady = ~rx_full_q;
  assign rx_push = RxValid & ~rx_full_q;
  assign rx_pop  = REUART & (UARTsel == UART_RXDATA);
  assign tx_hit  = WEUART & (UARTsel == UART_TXDATA);

  // RX holding register: pop clears, accept only when empty
  always_comb begin
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (rx_pop) rx_full_d = 1'b0;
    if (rx_push) begin
      rx_full_d = 1'b1;
      rx_byte_d = RxByte;
    end
  end

  // RX state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_full_q <= 1'b0;
      rx_byte_q <= '0;
    end else begin
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  // Read mux, zero whenever the CPU is not reading
  always_comb begin
    ReadData = '0;
    if (REUART) begin
      unique case (UARTsel)
        UART_RXCTRL: ReadData = {31'b0, rx_full_q};
        UART_RXDATA: ReadData = {24'b0, rx_byte_q};
        UART_TXCTRL: ReadData = {31'b0, tx_ready};
        UART_TXDATA: ReadData = '0;
        default:     ReadData = '0;
      endcase
    end
  end

`ifdef UART_TX_FIFO_EN
  localparam int PtrW = $clog2(TX_FIFO_DEPTH);
  localparam int CntW = $clog2(TX_FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] Full =
    CntW'(TX_FIFO_DEPTH);

  logic [7:0]      fifo_q [TX_FIFO_DEPTH];
  logic [7:0]      fifo_d [TX_FIFO_DEPTH];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push, pop;

  assign tx_ready  = (cnt_q != Full);
  assign ser_valid = (cnt_q != '0);
  assign ser_byte  = fifo_q[rd_q];
  assign pop       = ser_valid & ser_ready;
  assign push      = tx_hit & (tx_ready | pop);

  // FIFO bookkeeping; push+pop when full keeps count
  always_comb begin
    fifo_d = fifo_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (push) begin
      fifo_d[wr_q] = WriteData[7:0];
      wr_d = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // FIFO storage and pointers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < TX_FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      fifo_q <= fifo_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  // The serializer's shift register is the holding
  // register, so it is empty exactly when the FSM idles.
  assign tx_ready  = ser_ready;
  assign ser_valid = tx_hit;
  assign ser_byte  = WriteData[7:0];
`endif

  uart_tx_serializer #(
    .SymbolEdgeTime(SymbolEdgeTime)
  ) u_tx (
    .clk       (Clock),
    .rst       (Reset),
    .in_valid  (ser_valid),
    .in_byte   (ser_byte),
    .in_ready  (ser_ready),
    .serial_out(SerialOut)
  );

endmodule
